clock_works: RTL and testbench
==============================

// Module: clock_works
// PURPOSE
//  Board-level clock/reset conditioner sitting between the FPGA pins and the SoC.
//  - Divides the board clock CLK by 2^SLOW so instruction execution is human-visible on LEDs.
//  - Turns the RESET button into a stretched reset, released synchronously to the divided clock.
//  - All SoC logic runs on clk/reset; nothing downstream uses CLK/RESET directly.
// PARAMETERS
//  SLOW        24  divider exponent; clk = CLK / 2^SLOW; SLOW=0 -> clk is CLK (no divider)
//  RST_CYCLES  4   rising clk edges reset stays high after RESET is low; legal range 2..255
// PORTS
//  CLK    in   1  board clock, sole clock input
//  RESET  in   1  reset button; asynchronous, active-high
//  clk    out  1  divided system clock
//  reset  out  1  system reset, active-high; async assert, deassert synchronous to clk
// BEHAVIOUR
//  Clock and reset: one clock, CLK; RESET is asynchronous, active-high. Both polarity and synchronicity are fixed.
//  Divider:
//  - Free-running counter cnt[SLOW-1:0], +1 on every CLK rising edge; wraps at all-ones to 0.
//  - Power-up value 0 (register init).
//  - NOT affected by RESET: clk keeps toggling during reset so synchronous-reset users see edges.
//  - clk = cnt[SLOW-1] (registered bit, glitch-free).
//  - Period is 2^SLOW CLK cycles; duty cycle 50%.
//  - First clk rise follows the 2^(SLOW-1)-th CLK rising edge after power-up.
//  - SLOW=0: clk = CLK directly; no counter is generated.
//  Reset stretcher, clk domain:
//  - Counter rcnt, width clog2(RST_CYCLES+1); power-up value 0.
//  - RESET high -> rcnt cleared to 0 immediately (async); reset goes high the same instant.
//  - On each clk rising edge with RESET low: rcnt increments while rcnt != RST_CYCLES, then saturates. No wrap.
//  - reset = (rcnt != RST_CYCLES), decoded from registered state.
//  - reset therefore falls exactly on the RST_CYCLES-th clk rising edge after RESET deasserts.
//  - RST_CYCLES >= 2 gives the two-flop metastability margin for the asynchronous RESET release.
//  Power-up and timing:
//  - Power-up with RESET low: reset=1, clk=0; reset releases after RST_CYCLES clk rises.
//  - RESET re-asserted mid-stretch or after release: rcnt restarts from 0; full RST_CYCLES count again.
//  - RESET glitch shorter than one CLK cycle: still clears rcnt, giving a full stretch.
//  - No latency from RESET rise to reset rise beyond gate delay.
//  - No outputs other than clk/reset. All outputs defined at time 0 via register init values.
// STRUCTURE
//  - No shared package needed; local constant for rcnt width only.
//  - One natural sub-module: clock_divider (parameter SLOW; CLK in, clk out).
//  - Stretcher logic stays inline in clock_works.
//  - Synthesis note: clk is a fabric-derived clock; route it onto a global buffer where the target allows.
// TESTING (bench with SLOW=2, RST_CYCLES=4, CLK period 10ns)
//  1. Power-up, RESET=0:
//     - clk rises after CLK edge 2, then every 4 CLK edges (high 2, low 2).
//     - reset=1 at t=0; falls on the 4th clk rise (CLK edge 14).
//  2. Pulse RESET=1 for 3 CLK cycles after release:
//     - reset rises within the same cycle, asynchronously.
//     - clk keeps toggling unchanged.
//     - reset falls on the 4th clk rise after RESET falls.
//  3. Re-assert RESET while rcnt=2 (mid-stretch): rcnt returns to 0; reset held for a full 4 further clk rises.
//  4. 1ns RESET glitch between CLK edges: reset asserts, then deasserts 4 clk rises later.
//  5. SLOW=0 build: clk identical to CLK; reset released on the 4th CLK rise after RESET low.
//  6. Long run, 10,000 CLK cycles with RESET=0: clk period constant at 4; reset never re-asserts.

Source files
------------

// File: rtl/clock_works_pkg.sv
// -----------------------------------------------------------------------------
// clock_works_pkg
// Shared constants and helpers for the board clock/reset conditioner.
//   DEFAULT_SLOW       : divider exponent used when the top is not overridden
//   DEFAULT_RST_CYCLES : number of divided-clock rises the reset is stretched by
//   stretch_state_e    : decoded view of the reset stretcher
//   rcnt_width()       : width of a counter that must be able to hold 0..cycles
// -----------------------------------------------------------------------------
package clock_works_pkg;

  localparam int DEFAULT_SLOW       = 24;
  localparam int DEFAULT_RST_CYCLES = 4;

  // The stretcher is either still holding the SoC in reset or has released it.
  typedef enum logic {
    STRETCH_ACTIVE = 1'b0,
    STRETCH_DONE   = 1'b1
  } stretch_state_e;

  // The stretch counter saturates at exactly 'cycles', so it needs room for
  // that value itself, not just cycles-1.
  function automatic int rcnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/clock_works_if.sv
// -----------------------------------------------------------------------------
// clock_works_if
// System clock/reset bundle handed from the conditioner to the SoC.
//   clk   : divided system clock
//   reset : system reset, active-high, async assert, release synchronous to clk
// Modports:
//   master : the conditioner, drives clk and reset
//   slave  : any SoC block consuming clk and reset
// -----------------------------------------------------------------------------
interface clock_works_if;

  logic clk;
  logic reset;

  modport master (
    output clk,
    output reset
  );

  modport slave (
    input clk,
    input reset
  );

endinterface

// File: rtl/clock_works_clock_divider.sv
// -----------------------------------------------------------------------------
// clock_divider
// Free-running power-of-two divider for the board clock.
//   SLOW : divider exponent; clk = CLK / 2^SLOW, SLOW = 0 passes CLK through
// Ports:
//   CLK  in  board clock
//   clk  out divided clock, 50% duty, taken straight from a register bit
// The counter has no reset on purpose: the divided clock must keep running
// while the SoC is held in reset so synchronous-reset logic sees edges.
// clk is a fabric-derived clock; place it on a global buffer where the
// target allows.
// -----------------------------------------------------------------------------
module clock_divider
  import clock_works_pkg::*;
#(
  parameter int SLOW = DEFAULT_SLOW
) (
  input  logic CLK,
  output logic clk
);

  generate
    if (SLOW == 0) begin : g_passthrough
      // No division requested: hand the board clock straight through.
      assign clk = CLK;
    end else begin : g_counter
      // Starts at zero from the register init value, so the first clk rise
      // lands on the 2^(SLOW-1)-th CLK rise after power-up.
      logic [SLOW-1:0] cnt = '0;

      always_ff @(posedge CLK) begin
        cnt <= cnt + SLOW'(1);
      end

      // The MSB is itself a flop output, so clk cannot glitch.
      assign clk = cnt[SLOW-1];
    end
  endgenerate

endmodule

// File: rtl/clock_works.sv
// -----------------------------------------------------------------------------
// clock_works
// Board-level clock/reset conditioner between the FPGA pins and the SoC.
//   SLOW       : divider exponent, clk = CLK / 2^SLOW (0 = no divider)
//   RST_CYCLES : clk rises the reset is held after RESET drops (2..255)
// Ports:
//   CLK    in   board clock, the only clock input
//   RESET  in   reset button, asynchronous, active-high
//   sys    out  clock_works_if master: divided clk and stretched reset
// All SoC logic runs on sys.clk / sys.reset; nothing downstream should touch
// CLK or RESET directly.
// -----------------------------------------------------------------------------
module clock_works
  import clock_works_pkg::*;
#(
  parameter int SLOW       = DEFAULT_SLOW,
  parameter int RST_CYCLES = DEFAULT_RST_CYCLES
) (
  input  logic          CLK,
  input  logic          RESET,
  clock_works_if.master sys
);

  localparam int                RCNT_W    = rcnt_width(RST_CYCLES);
  localparam logic [RCNT_W-1:0] RCNT_DONE = RCNT_W'(RST_CYCLES);

  logic              clk_div;
  logic [RCNT_W-1:0] rcnt = '0;
  stretch_state_e    stretch_state;

  clock_divider #(
    .SLOW (SLOW)
  ) u_divider (
    .CLK (CLK),
    .clk (clk_div)
  );

  // Reset stretcher. RESET clears the count asynchronously, so even a
  // glitch narrower than a CLK period restarts a full stretch. Release is
  // counted on clk rises, which makes the fall of reset synchronous to clk;
  // with RST_CYCLES >= 2 the first two counts act as a metastability filter
  // for the asynchronous RESET release. The count saturates and never wraps.
  always_ff @(posedge clk_div or posedge RESET) begin
    if (RESET) begin
      rcnt <= '0;
    end else if (rcnt != RCNT_DONE) begin
      rcnt <= rcnt + RCNT_W'(1);
    end
  end

  // Decode the stretcher from registered state only, so reset is clean and
  // rises in the same instant the count is cleared.
  always_comb begin
    stretch_state = STRETCH_ACTIVE;
    if (rcnt == RCNT_DONE) begin
      stretch_state = STRETCH_DONE;
    end
  end

  assign sys.clk   = clk_div;
  assign sys.reset = (stretch_state == STRETCH_ACTIVE);

endmodule

// File: tb/tb_clock_works.sv
// -----------------------------------------------------------------------------
// tb_clock_works
// Self-checking bench for clock_works. Two builds share one CLK/RESET pair:
//   dut_div : SLOW=2, RST_CYCLES=4 (divided clock, period 4 CLK cycles)
//   dut_raw : SLOW=0, RST_CYCLES=4 (clk is CLK itself)
// Expected outputs come from counting CLK rises since power-up and since the
// last RESET release, then working out how many system-clock rises fell in
// that window by plain arithmetic.
// -----------------------------------------------------------------------------
module tb_clock_works;

  localparam int SLOW_DIV = 2;
  localparam int RST_N    = 4;
  localparam int PERIOD   = 2 ** SLOW_DIV;
  localparam int HALF     = PERIOD / 2;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  clock_works_if sys_div ();
  clock_works_if sys_raw ();

  clock_works #(
    .SLOW       (SLOW_DIV),
    .RST_CYCLES (RST_N)
  ) dut_div (
    .CLK   (CLK),
    .RESET (RESET),
    .sys   (sys_div)
  );

  clock_works #(
    .SLOW       (0),
    .RST_CYCLES (RST_N)
  ) dut_raw (
    .CLK   (CLK),
    .RESET (RESET),
    .sys   (sys_raw)
  );

  // 10 ns board clock, first rise at 5 ns.
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  int n_edges     = 0;
  int last_rel    = 0;

  // Divided-clock rises among CLK rises 1..edges: clk rises on every CLK rise
  // whose index is HALF modulo PERIOD.
  function automatic int div_rises(input int edges);
    return (edges + HALF) / PERIOD;
  endfunction

  task automatic check_output(input string tag, input logic observed, input logic expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s at edge %0d: observed %b expected %b", tag, n_edges, observed, expected);
    end
  endtask

  // Compare all four outputs against the model at the current point in time.
  task automatic check_all(input string tag, input logic clk_level);
    logic exp_clk_div;
    logic exp_rst_div;
    logic exp_rst_raw;
    exp_clk_div = ((n_edges / HALF) % 2) == 1;
    exp_rst_div = RESET || ((div_rises(n_edges) - div_rises(last_rel)) < RST_N);
    exp_rst_raw = RESET || ((n_edges - last_rel) < RST_N);
    check_output({tag, ".div_clk"},   sys_div.clk,   exp_clk_div);
    check_output({tag, ".div_reset"}, sys_div.reset, exp_rst_div);
    check_output({tag, ".raw_clk"},   sys_raw.clk,   clk_level);
    check_output({tag, ".raw_reset"}, sys_raw.reset, exp_rst_raw);
  endtask

  // Advance one CLK cycle, checking just after the rise and after the fall.
  // Leaves time 1 ns after the falling edge, well clear of either edge.
  task automatic step_clock(input string tag);
    @(posedge CLK);
    n_edges++;
    #2;
    check_all({tag, ".hi"}, 1'b1);
    @(negedge CLK);
    #1;
    check_all({tag, ".lo"}, 1'b0);
  endtask

  task automatic step_many(input string tag, input int count);
    for (int i = 0; i < count; i++) begin
      step_clock(tag);
    end
  endtask

  // kind 0: RESET pulse lasting len CLK cycles; kind 1: 1 ns glitch between
  // CLK edges; anything else: leave RESET alone.
  task automatic apply_stimulus(input int kind, input int len);
    if (kind == 0) begin
      RESET = 1'b1;
      #1;
      check_all("pulse_assert", 1'b0);
      step_many("pulse_hold", len);
      RESET = 1'b0;
      last_rel = n_edges;
    end else if (kind == 1) begin
      RESET = 1'b1;
      #1;
      check_all("glitch_assert", 1'b0);
      RESET = 1'b0;
      last_rel = n_edges;
    end
  endtask

  initial begin
    int found;
    int kind;
    int len;
    int gap;

    // Power-up: reset asserted and divided clock low before any CLK edge.
    #1;
    check_all("powerup", 1'b0);

    // Release from power-up: div reset must fall on CLK rise 14.
    step_many("powerup_release", 16);
    $display("[TB] power-up release checked up to edge %0d", n_edges);

    // Multi-cycle pulse after release, then a full stretch.
    apply_stimulus(0, 3);
    step_many("pulse_release", 20);

    // Re-assert mid-stretch once two divided-clock rises have been counted.
    apply_stimulus(0, 2);
    found = 0;
    for (int i = 0; i < 16 && found == 0; i++) begin
      if ((div_rises(n_edges) - div_rises(last_rel)) == 2) begin
        found = 1;
      end else begin
        step_clock("mid_seek");
      end
    end
    check_output("mid_stretch_reached", found[0], 1'b1);
    apply_stimulus(0, 1);
    step_many("mid_restart", 20);

    // Narrow glitch between CLK edges.
    apply_stimulus(1, 0);
    step_many("glitch_release", 20);

    // Randomised mix of pulses, glitches and idle gaps.
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      len  = $urandom_range(1, 6);
      gap  = $urandom_range(0, 20);
      apply_stimulus(kind, len);
      step_many("random", gap);
    end

    // Long quiet run: clock period stays at 4 and reset stays released.
    step_many("settle", 20);
    step_many("long_run", 10000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
